regfile_bypass: RTL and testbench

Parametrised successor to the single-cycle MIPS register file for the pipelined datapath. Provides NUM_RD combinational read ports with same-cycle write-to-read bypass, a hardwired-zero register 0 and a dedicated link-write path for JAL/JALR. It also keeps a per-register pending-load scoreboard, so the decode stage can stall on operands whose load has not yet written back. The block sits between decode (reads, pending set) and writeback (writes).

---
 rtl/regfile_bypass_pkg.sv | 16 +
 rtl/regfile_scoreboard.sv | 47 ++++
 rtl/regfile_bypass.sv | 98 +++++++++
 tb/tb_regfile_bypass.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_bypass_pkg.sv
// Shared defaults and helpers for the pipelined register file slice.
package regfile_bypass_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_LINK_REG = 31;

  // Index of the hardwired-zero register
  localparam int ZERO_REG = 0;

  // Base bit offset of port 'port' inside a flattened bus of 'width'-bit fields
  function automatic int portBase(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one bit per register, set by load issue, cleared by writeback.
module regfile_scoreboard
  import regfile_bypass_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] readReg,
  input  logic                     pendSet,
  input  logic [ADDR_W-1:0]        pendReg,
  input  logic [2**ADDR_W-1:0]     clrMask,
  output logic [NUM_RD-1:0]        busy,
  output logic [2**ADDR_W-1:0]     pendMask
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] setMask;

  // One-hot set request; register 0 can never become pending
  always_comb begin
    setMask = '0;
    if (pendSet && (pendReg != ADDR_W'(ZERO_REG)))
      setMask[pendReg] = 1'b1;
  end

  // Clear first, then set, so a newer load on the same register stays outstanding
  always_ff @(posedge clk) begin
    if (rst)
      pendMask <= '0;
    else
      pendMask <= ((pendMask & ~clrMask) | setMask) & ~DEPTH'(1);
  end

  // A register written this cycle is satisfied by the bypass, so it does not stall
  genvar i;
  generate
    for (i = 0; i < NUM_RD; i++) begin : gBusy
      logic [ADDR_W-1:0] rdIdx;
      assign rdIdx   = readReg[portBase(i, ADDR_W) +: ADDR_W];
      assign busy[i] = pendMask[rdIdx] && !clrMask[rdIdx];
    end
  endgenerate

endmodule

// File: rtl/regfile_bypass.sv
// Multi-port register file with write-to-read bypass, hardwired r0, link write
// path and pending-load scoreboard.
module regfile_bypass
  import regfile_bypass_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int LINK_REG = DEF_LINK_REG
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] readReg,
  output logic [NUM_RD*DATA_W-1:0] readDat,
  output logic [NUM_RD-1:0]        busy,
  input  logic                     regWrite,
  input  logic [ADDR_W-1:0]        writeReg,
  input  logic [DATA_W-1:0]        writeData,
  input  logic                     linkWrite,
  input  logic [DATA_W-1:0]        linkData,
  input  logic                     pendSet,
  input  logic [ADDR_W-1:0]        pendReg,
  output logic [2**ADDR_W-1:0]     pendMask
);

  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              linkEn;
  logic              regEn;
  logic [DEPTH-1:0]  clrMask;

  // Write arbitration: link path beats writeback when both target LINK_REG
  always_comb begin
    linkEn = linkWrite && (LINK_IDX != ZERO_IDX);
    regEn  = regWrite && (writeReg != ZERO_IDX) && !(linkEn && (writeReg == LINK_IDX));
  end

  // Registers effectively written this cycle (clears scoreboard, releases busy)
  always_comb begin
    clrMask = '0;
    if (linkEn)
      clrMask[LINK_IDX] = 1'b1;
    if (regEn)
      clrMask[writeReg] = 1'b1;
  end

  // Register array; r0 is never written so it stays zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++)
        regs[r] <= '0;
    end else begin
      if (linkEn)
        regs[LINK_IDX] <= linkData;
      if (regEn)
        regs[writeReg] <= writeData;
    end
  end

  // Read ports: zero register, then same-cycle bypass, then array
  genvar i;
  generate
    for (i = 0; i < NUM_RD; i++) begin : gRead
      logic [ADDR_W-1:0] rdIdx;
      logic [DATA_W-1:0] rdVal;
      assign rdIdx = readReg[portBase(i, ADDR_W) +: ADDR_W];
      always_comb begin
        if (rdIdx == ZERO_IDX)
          rdVal = '0;
        else if (linkEn && (rdIdx == LINK_IDX))
          rdVal = linkData;
        else if (regEn && (rdIdx == writeReg))
          rdVal = writeData;
        else
          rdVal = regs[rdIdx];
      end
      assign readDat[portBase(i, DATA_W) +: DATA_W] = rdVal;
    end
  endgenerate

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) uScoreboard (
    .clk      (clk),
    .rst      (rst),
    .readReg  (readReg),
    .pendSet  (pendSet),
    .pendReg  (pendReg),
    .clrMask  (clrMask),
    .busy     (busy),
    .pendMask (pendMask)
  );

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass: inputs change on negedge, checks 1ns later.
module tb_regfile_bypass;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  readReg;
  logic [63:0] readDat;
  logic [1:0]  busy;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        linkWrite;
  logic [31:0] linkData;
  logic        pendSet;
  logic [4:0]  pendReg;
  logic [31:0] pendMask;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_bypass #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .NUM_RD   (2),
    .LINK_REG (31)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .readReg   (readReg),
    .readDat   (readDat),
    .busy      (busy),
    .regWrite  (regWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .linkWrite (linkWrite),
    .linkData  (linkData),
    .pendSet   (pendSet),
    .pendReg   (pendReg),
    .pendMask  (pendMask)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    regWrite  = 1'b0;
    linkWrite = 1'b0;
    pendSet   = 1'b0;
    writeReg  = '0;
    writeData = '0;
    linkData  = '0;
    pendReg   = '0;
  endtask

  task automatic setRead(input logic [4:0] r0, input logic [4:0] r1);
    readReg = {r1, r0};
  endtask

  initial begin
    rst = 1'b1;
    idle();
    setRead(5'd0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state across every index on both ports
    for (int r = 0; r < 32; r++) begin
      setRead(5'(r), 5'(31 - r));
      #0.1;
      chk($sformatf("rst_rd0_r%0d", r), readDat[31:0], 64'h0);
      chk($sformatf("rst_rd1_r%0d", 31 - r), readDat[63:32], 64'h0);
      chk($sformatf("rst_busy_r%0d", r), busy, 64'h0);
    end
    chk("rst_pendMask", pendMask, 64'h0);

    // Writeback bypass then array read
    @(negedge clk);
    regWrite = 1'b1; writeReg = 5'd5; writeData = 32'hDEADBEEF;
    setRead(5'd5, 5'd0);
    #1 chk("wr5_bypass", readDat[31:0], 64'hDEADBEEF);
    @(negedge clk);
    idle();
    #1 chk("wr5_array", readDat[31:0], 64'hDEADBEEF);

    // Writes to r0 are ignored
    @(negedge clk);
    regWrite = 1'b1; writeReg = 5'd0; writeData = 32'h1234;
    setRead(5'd0, 5'd0);
    #1 chk("wr0_same", readDat[31:0], 64'h0);
    @(negedge clk);
    idle();
    #1 chk("wr0_after", readDat[63:32], 64'h0);

    // Link and writeback both target r31: link wins
    @(negedge clk);
    linkWrite = 1'b1; linkData = 32'h00400008;
    regWrite = 1'b1; writeReg = 5'd31; writeData = 32'h0000FFFF;
    setRead(5'd5, 5'd31);
    #1 chk("link_conf_bypass", readDat[63:32], 64'h00400008);
    @(negedge clk);
    idle();
    #1 chk("link_conf_array", readDat[63:32], 64'h00400008);

    // Link and writeback to different registers both commit
    @(negedge clk);
    linkWrite = 1'b1; linkData = 32'h00400010;
    regWrite = 1'b1; writeReg = 5'd7; writeData = 32'h55;
    setRead(5'd7, 5'd31);
    #1 chk("dual_r7_bypass", readDat[31:0], 64'h55);
    chk("dual_r31_bypass", readDat[63:32], 64'h00400010);
    @(negedge clk);
    idle();
    #1 chk("dual_r7_array", readDat[31:0], 64'h55);
    chk("dual_r31_array", readDat[63:32], 64'h00400010);
    chk("dual_r5_kept", {32'h0, dut.regs[5]}, 64'h00000000DEADBEEF);

    // Load pending on r9 stalls until writeback bypasses it
    @(negedge clk);
    pendSet = 1'b1; pendReg = 5'd9;
    setRead(5'd0, 5'd9);
    #1 chk("pend_busy_before_edge", busy, 64'h0);
    @(negedge clk);
    idle();
    #1 chk("pend_busy", busy, 64'h2);
    chk("pend_mask9", pendMask, 64'h00000200);
    @(negedge clk);
    regWrite = 1'b1; writeReg = 5'd9; writeData = 32'hA5;
    #1 chk("pend_release_busy", busy, 64'h0);
    chk("pend_release_data", readDat[63:32], 64'hA5);
    chk("pend_mask_until_edge", pendMask, 64'h00000200);
    @(negedge clk);
    idle();
    #1 chk("pend_cleared", pendMask, 64'h0);
    chk("pend_cleared_busy", busy, 64'h0);
    chk("pend_data_array", readDat[63:32], 64'hA5);

    // Same-cycle set and clear on r9: set wins
    @(negedge clk);
    pendSet = 1'b1; pendReg = 5'd9;
    regWrite = 1'b1; writeReg = 5'd9; writeData = 32'h3C;
    @(negedge clk);
    idle();
    #1 chk("setclr_mask", pendMask, 64'h00000200);
    chk("setclr_busy", busy, 64'h2);
    chk("setclr_data", readDat[63:32], 64'h3C);

    // pendSet to r0 ignored; also load r3 with a value for the reset check
    @(negedge clk);
    pendSet = 1'b1; pendReg = 5'd0;
    regWrite = 1'b1; writeReg = 5'd3; writeData = 32'h11;
    @(negedge clk);
    idle();
    setRead(5'd3, 5'd0);
    #1 chk("pend0_ignored", pendMask, 64'h00000200);
    chk("pend0_busy", busy, 64'h0);
    chk("r3_before_rst", readDat[31:0], 64'h11);

    // Reset mid-operation discards the write and pendSet presented with it
    @(negedge clk);
    rst = 1'b1;
    regWrite = 1'b1; writeReg = 5'd3; writeData = 32'h77;
    pendSet = 1'b1; pendReg = 5'd4;
    @(negedge clk);
    rst = 1'b0;
    idle();
    setRead(5'd3, 5'd9);
    #1 chk("rst_mid_r3", readDat[31:0], 64'h0);
    chk("rst_mid_r9", readDat[63:32], 64'h0);
    chk("rst_mid_mask", pendMask, 64'h0);
    chk("rst_mid_busy", busy, 64'h0);
    setRead(5'd31, 5'd7);
    #1 chk("rst_mid_r31", readDat[31:0], 64'h0);
    chk("rst_mid_r7", readDat[63:32], 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
